// File: rtl/decrypt_pkg.sv
// Shared definitions for the decryptor datapath: channel indices, default width, clog2 helper.
package decrypt_pkg;

    localparam int unsigned CH_CAESAR       = 0;
    localparam int unsigned CH_SCYTALE      = 1;
    localparam int unsigned CH_ZIGZAG       = 2;

    localparam int unsigned DEFAULT_D_WIDTH = 8;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy register; head word reads as 0 when empty.
module sync_fifo
    import decrypt_pkg::*;
#(
    parameter int unsigned D_WIDTH = DEFAULT_D_WIDTH,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic [D_WIDTH-1:0]        wdata_i,
    input  logic                      pop_i,
    output logic [D_WIDTH-1:0]        rdata_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [clog2(DEPTH):0]     level_o
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [D_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               wr_en;
    logic               rd_en;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

    // Next-state for pointers and occupancy; a write into a full FIFO is allowed only with a pop.
    always_comb begin
        rd_en    = pop_i && !empty_o;
        wr_en    = push_i && (!full_o || rd_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care while the occupancy says empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Head word, forced to zero when nothing is queued.
    always_comb begin
        rdata_o = '0;
        if (!empty_o) begin
            rdata_o = mem_q[rd_ptr_q];
        end
    end

endmodule

// File: rtl/decrypt_out_mux.sv
// Decryptor output stage: picks one engine stream, queues its words and hands them downstream
// over valid/ready, counting overflow drops and flagging illegal selects.
module decrypt_out_mux
    import decrypt_pkg::*;
#(
    parameter int unsigned D_WIDTH = DEFAULT_D_WIDTH,
    parameter int unsigned N_CH    = 3,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SEL_W-1:0]          select,
    input  logic [N_CH*D_WIDTH-1:0]   data_i,
    input  logic [N_CH-1:0]           valid_i,
    output logic [D_WIDTH-1:0]        data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [clog2(DEPTH):0]     level_o,
    output logic [CNT_W-1:0]          drop_cnt_o,
    output logic                      sel_err_o
);

    logic [D_WIDTH-1:0] sel_data;
    logic               sel_valid;
    logic               sel_legal;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               push_en;
    logic               overflow;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic               sel_err_q, sel_err_d;

    // Channel mux; an out-of-range select matches no channel, so it can never push.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (select == SEL_W'(k)) begin
                sel_data  = data_i[k*D_WIDTH +: D_WIDTH];
                sel_valid = valid_i[k];
            end
        end
    end

    // Push / pop / overflow decision and next-state for the counters.
    always_comb begin
        sel_legal  = (32'(select) < N_CH);
        pop        = ready_i && !fifo_empty;
        push_en    = sel_valid && (!fifo_full || pop);
        overflow   = sel_valid && fifo_full && !pop;
        sel_err_d  = !sel_legal && (|valid_i);
        drop_cnt_d = drop_cnt_q;
        if (overflow && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    // Drop counter and illegal-select pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
            sel_err_q  <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            sel_err_q  <= sel_err_d;
        end
    end

    sync_fifo #(
        .D_WIDTH (D_WIDTH),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_en),
        .wdata_i (sel_data),
        .pop_i   (pop),
        .rdata_o (data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    assign valid_o    = !fifo_empty;
    assign drop_cnt_o = drop_cnt_q;
    assign sel_err_o  = sel_err_q;

endmodule

// File: tb/tb_decrypt_out_mux.sv
// Directed bench for decrypt_out_mux with default parameters (8-bit, 3 channels, depth 4).
module tb_decrypt_out_mux;
    import decrypt_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  select = '0;
    logic [23:0] data_i = '0;
    logic [2:0]  valid_i = '0;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [2:0]  level_o;
    logic [15:0] drop_cnt_o;
    logic        sel_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    decrypt_out_mux dut (
        .clk        (clk),
        .rst        (rst),
        .select     (select),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .level_o    (level_o),
        .drop_cnt_o (drop_cnt_o),
        .sel_err_o  (sel_err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [7:0] v);
        data_i[k*8 +: 8] = v;
    endtask

    task automatic test_reset();
        tick();
        n_cmp++; if (data_o !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", data_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid_o); end
        n_cmp++; if (level_o !== 3'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", level_o); end
        n_cmp++; if (drop_cnt_o !== 16'd0) begin n_bad++; $display("FAIL reset_drop got %0d want 0", drop_cnt_o); end
        n_cmp++; if (sel_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_selerr got %b want 0", sel_err_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
        select  = 2'(CH_CAESAR);
        ready_i = 1'b1;
        valid_i = 3'b001;
        for (int i = 0; i < 3; i++) begin
            set_ch(0, exp[i]);
            tick();
            n_cmp++; if (data_o !== exp[i]) begin n_bad++; $display("FAIL b2b_data[%0d] got %h want %h", i, data_o, exp[i]); end
            n_cmp++; if (level_o !== 3'd1) begin n_bad++; $display("FAIL b2b_level[%0d] got %0d want 1", i, level_o); end
        end
        valid_i = 3'b000;
        tick();
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_drain_valid got %b want 0", valid_o); end
        n_cmp++; if (data_o !== 8'h00) begin n_bad++; $display("FAIL b2b_drain_data got %h want 00", data_o); end
    endtask

    task automatic test_overflow();
        ready_i = 1'b0;
        select  = 2'(CH_SCYTALE);
        valid_i = 3'b010;
        for (int i = 0; i < 6; i++) begin
            set_ch(1, 8'(8'h10 + i));
            set_ch(0, 8'hAA);
            tick();
        end
        valid_i = 3'b000;
        n_cmp++; if (level_o !== 3'd4) begin n_bad++; $display("FAIL ovf_level got %0d want 4", level_o); end
        n_cmp++; if (drop_cnt_o !== 16'd2) begin n_bad++; $display("FAIL ovf_drop got %0d want 2", drop_cnt_o); end
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (data_o !== 8'(8'h10 + i)) begin n_bad++; $display("FAIL ovf_drain[%0d] got %h want %h", i, data_o, 8'(8'h10 + i)); end
            tick();
        end
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL ovf_empty got %b want 0", valid_o); end
        n_cmp++; if (drop_cnt_o !== 16'd2) begin n_bad++; $display("FAIL ovf_drop_hold got %0d want 2", drop_cnt_o); end
    endtask

    task automatic test_full_push_pop();
        ready_i = 1'b0;
        select  = 2'(CH_SCYTALE);
        valid_i = 3'b010;
        for (int i = 0; i < 4; i++) begin
            set_ch(1, 8'(8'h20 + i));
            tick();
        end
        n_cmp++; if (level_o !== 3'd4) begin n_bad++; $display("FAIL fpp_fill got %0d want 4", level_o); end
        ready_i = 1'b1;
        set_ch(1, 8'h24);
        tick();
        valid_i = 3'b000;
        n_cmp++; if (level_o !== 3'd4) begin n_bad++; $display("FAIL fpp_level got %0d want 4", level_o); end
        n_cmp++; if (drop_cnt_o !== 16'd2) begin n_bad++; $display("FAIL fpp_drop got %0d want 2", drop_cnt_o); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (data_o !== 8'(8'h21 + i)) begin n_bad++; $display("FAIL fpp_drain[%0d] got %h want %h", i, data_o, 8'(8'h21 + i)); end
            tick();
        end
        n_cmp++; if (level_o !== 3'd0) begin n_bad++; $display("FAIL fpp_empty got %0d want 0", level_o); end
    endtask

    task automatic test_sel_err();
        ready_i = 1'b0;
        select  = 2'(CH_CAESAR);
        valid_i = 3'b001;
        set_ch(0, 8'h55);
        tick();
        select  = 2'd3;
        valid_i = 3'b111;
        n_cmp++; if (sel_err_o !== 1'b0) begin n_bad++; $display("FAIL selerr_pre got %b want 0", sel_err_o); end
        tick();
        valid_i = 3'b000;
        n_cmp++; if (sel_err_o !== 1'b1) begin n_bad++; $display("FAIL selerr_pulse got %b want 1", sel_err_o); end
        n_cmp++; if (level_o !== 3'd1) begin n_bad++; $display("FAIL selerr_level got %0d want 1", level_o); end
        tick();
        n_cmp++; if (sel_err_o !== 1'b0) begin n_bad++; $display("FAIL selerr_end got %b want 0", sel_err_o); end
        n_cmp++; if (data_o !== 8'h55) begin n_bad++; $display("FAIL selerr_head got %h want 55", data_o); end
        ready_i = 1'b1;
        select  = 2'(CH_CAESAR);
        tick();
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL selerr_drain got %b want 0", valid_o); end
    endtask

    task automatic test_select_switch();
        logic [7:0] exp [4];
        exp[0] = 8'h30; exp[1] = 8'h31; exp[2] = 8'h70; exp[3] = 8'h71;
        ready_i = 1'b0;
        select  = 2'(CH_CAESAR);
        valid_i = 3'b001;
        set_ch(0, 8'h30); tick();
        set_ch(0, 8'h31); tick();
        select  = 2'(CH_ZIGZAG);
        valid_i = 3'b101;
        set_ch(0, 8'hEE); set_ch(2, 8'h70); tick();
        valid_i = 3'b100;
        set_ch(0, 8'hEF); set_ch(2, 8'h71); tick();
        valid_i = 3'b001;
        set_ch(0, 8'hE0); tick();
        valid_i = 3'b000;
        n_cmp++; if (level_o !== 3'd4) begin n_bad++; $display("FAIL sw_level got %0d want 4", level_o); end
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (data_o !== exp[i]) begin n_bad++; $display("FAIL sw_order[%0d] got %h want %h", i, data_o, exp[i]); end
            tick();
        end
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL sw_empty got %b want 0", valid_o); end
    endtask

    task automatic test_reset_mid();
        ready_i = 1'b0;
        select  = 2'(CH_CAESAR);
        valid_i = 3'b001;
        for (int i = 0; i < 3; i++) begin
            set_ch(0, 8'(8'h60 + i));
            tick();
        end
        n_cmp++; if (level_o !== 3'd3) begin n_bad++; $display("FAIL rmid_level got %0d want 3", level_o); end
        rst = 1'b1;
        #2;
        n_cmp++; if (level_o !== 3'd0) begin n_bad++; $display("FAIL rmid_async_level got %0d want 0", level_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_async_valid got %b want 0", valid_o); end
        n_cmp++; if (data_o !== 8'h00) begin n_bad++; $display("FAIL rmid_async_data got %h want 00", data_o); end
        n_cmp++; if (drop_cnt_o !== 16'd0) begin n_bad++; $display("FAIL rmid_async_drop got %0d want 0", drop_cnt_o); end
        valid_i = 3'b000;
        tick();
        rst = 1'b0;
        valid_i = 3'b001;
        set_ch(0, 8'h77);
        tick();
        valid_i = 3'b000;
        n_cmp++; if (level_o !== 3'd1) begin n_bad++; $display("FAIL rmid_post_level got %0d want 1", level_o); end
        n_cmp++; if (data_o !== 8'h77) begin n_bad++; $display("FAIL rmid_post_data got %h want 77", data_o); end
        ready_i = 1'b1;
        tick();
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_sole got %b want 0", valid_o); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_sel_err();
        test_select_switch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
